// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the Mini SRC control unit: widths, FSM steps,
// opcode encodings, instruction classes and the control-word layout.
package cpu_defs_pkg;

    localparam int OPW  = 5;
    localparam int ALUW = 5;

    typedef enum logic [3:0] {
        T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_BR   = 5'b00100;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00101;
    localparam logic [OPW-1:0] OP_AND  = 5'b00110;
    localparam logic [OPW-1:0] OP_OR   = 5'b00111;
    localparam logic [OPW-1:0] OP_SHR  = 5'b01000;
    localparam logic [OPW-1:0] OP_SHL  = 5'b01001;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01010;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01011;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01100;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01101;
    localparam logic [OPW-1:0] OP_DIV  = 5'b01110;
    localparam logic [OPW-1:0] OP_JR   = 5'b01111;
    localparam logic [OPW-1:0] OP_MFHI = 5'b10000;
    localparam logic [OPW-1:0] OP_MFLO = 5'b10001;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11000;
    localparam logic [OPW-1:0] OP_HALT = 5'b11001;

    // One-hot instruction class; nop also covers every undefined opcode.
    typedef struct packed {
        logic r_alu;
        logic i_alu;
        logic ldi;
        logic ld;
        logic st;
        logic br;
        logic jr;
        logic mfhi;
        logic mflo;
        logic muldiv;
        logic halt;
        logic nop;
    } iclass_t;

    // Registered DataPath control word (alu_op kept separately).
    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic pc_in;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic zlow_out;
        logic zhigh_out;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic ba_out;
        logic c_out;
        logic hi_in;
        logic hi_out;
        logic lo_in;
        logic lo_out;
        logic con_in;
        logic md_read;
        logic ram_read;
        logic ram_write;
    } ctrl_t;

endpackage

// File: rtl/control_unit_opcode_decoder.sv
// Combinational opcode -> instruction class decoder.
// CONTROL_UNIT_MULDIV_EN: when defined, mul/div decode to their own class;
// otherwise they decode as nop.
module opcode_decoder
    import cpu_defs_pkg::*;
(
    input  logic [OPW-1:0] opcode,
    output iclass_t        iclass
);

    // Map each opcode to exactly one class bit.
    always_comb begin
        iclass = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: iclass.r_alu = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI:                      iclass.i_alu = 1'b1;
            OP_LDI:                                        iclass.ldi   = 1'b1;
            OP_LD:                                         iclass.ld    = 1'b1;
            OP_ST:                                         iclass.st    = 1'b1;
            OP_BR:                                         iclass.br    = 1'b1;
            OP_JR:                                         iclass.jr    = 1'b1;
            OP_MFHI:                                       iclass.mfhi  = 1'b1;
            OP_MFLO:                                       iclass.mflo  = 1'b1;
            OP_HALT:                                       iclass.halt  = 1'b1;
`ifdef CONTROL_UNIT_MULDIV_EN
            OP_MUL, OP_DIV:                                iclass.muldiv = 1'b1;
`else
            OP_MUL, OP_DIV:                                iclass.nop    = 1'b1;
`endif
            default:                                       iclass.nop   = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC control FSM: fetch T0-T2, class-specific T3-T7, HALT.
// Control outputs are registered from the next step, so they line up with
// the current step. mul/div sequencing depends on CONTROL_UNIT_MULDIV_EN
// (see opcode_decoder).
module control_unit
    import cpu_defs_pkg::*;
(
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     instruction,
    input  logic            CON,
    input  logic            stop,
    output logic            run,
    output logic            PCout,
    output logic            MARin,
    output logic            IncPC,
    output logic            PCin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            Zlowout,
    output logic            Zhighout,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic            Cout,
    output logic            HIin,
    output logic            HIout,
    output logic            LOin,
    output logic            LOout,
    output logic            CONin,
    output logic            MD_read,
    output logic            ram_read,
    output logic            ram_write,
    output logic [ALUW-1:0] alu_op
);

    logic [OPW-1:0]  opcode;
    logic            unused_ir;
    iclass_t         cls;
    state_t          state, state_nxt;
    logic            primed;
    logic            stop_pend;
    logic            stop_req;
    state_t          boundary;
    ctrl_t           ctrl_q, ctrl_nxt;
    logic [ALUW-1:0] alu_q, alu_nxt;
    logic            run_q;
    logic            br_t6_q, br_t6_nxt;

    assign opcode    = instruction[31:27];
    assign unused_ir = ^instruction[26:0];

    opcode_decoder u_decoder (
        .opcode (opcode),
        .iclass (cls)
    );

    assign stop_req = stop | stop_pend;
    assign boundary = stop_req ? HALT : T0;

    // Next step: advance through T-steps, leaving at the class's last step.
    always_comb begin
        state_nxt = state;
        case (state)
            T0:      state_nxt = T1;
            T1:      state_nxt = T2;
            T2:      state_nxt = cls.halt ? HALT : (cls.nop ? boundary : T3);
            T3:      state_nxt = (cls.jr | cls.mfhi | cls.mflo) ? boundary : T4;
            T4:      state_nxt = T5;
            T5:      state_nxt = (cls.r_alu | cls.i_alu | cls.ldi) ? boundary : T6;
            T6:      state_nxt = (cls.br | cls.muldiv) ? boundary : T7;
            T7:      state_nxt = boundary;
            HALT:    state_nxt = HALT;
            default: state_nxt = T0;
        endcase
        // Reset leaves outputs cleared while sitting in T0; hold T0 for one
        // more edge so the first fetch still drives its T0 strobes.
        if (!primed) state_nxt = T0;
    end

    // Control word for the step being entered.
    always_comb begin
        ctrl_nxt  = '0;
        alu_nxt   = '0;
        br_t6_nxt = 1'b0;
        case (state_nxt)
            T0: begin
                ctrl_nxt.pc_out = 1'b1; ctrl_nxt.mar_in = 1'b1;
                ctrl_nxt.inc_pc = 1'b1; ctrl_nxt.z_in   = 1'b1;
                alu_nxt = OP_ADD;
            end
            T1: begin
                ctrl_nxt.zlow_out = 1'b1; ctrl_nxt.pc_in   = 1'b1;
                ctrl_nxt.ram_read = 1'b1; ctrl_nxt.md_read = 1'b1;
                ctrl_nxt.mdr_in   = 1'b1;
            end
            T2: begin
                ctrl_nxt.mdr_out = 1'b1; ctrl_nxt.ir_in = 1'b1;
            end
            T3: begin
                if (cls.r_alu | cls.i_alu) begin
                    ctrl_nxt.grb = 1'b1; ctrl_nxt.r_out = 1'b1; ctrl_nxt.y_in = 1'b1;
                end
                if (cls.ldi | cls.ld | cls.st) begin
                    ctrl_nxt.grb = 1'b1; ctrl_nxt.ba_out = 1'b1; ctrl_nxt.y_in = 1'b1;
                end
                if (cls.br) begin
                    ctrl_nxt.gra = 1'b1; ctrl_nxt.r_out = 1'b1; ctrl_nxt.con_in = 1'b1;
                end
                if (cls.jr) begin
                    ctrl_nxt.gra = 1'b1; ctrl_nxt.r_out = 1'b1; ctrl_nxt.pc_in = 1'b1;
                end
                if (cls.mfhi) begin
                    ctrl_nxt.hi_out = 1'b1; ctrl_nxt.gra = 1'b1; ctrl_nxt.r_in = 1'b1;
                end
                if (cls.mflo) begin
                    ctrl_nxt.lo_out = 1'b1; ctrl_nxt.gra = 1'b1; ctrl_nxt.r_in = 1'b1;
                end
                if (cls.muldiv) begin
                    ctrl_nxt.gra = 1'b1; ctrl_nxt.r_out = 1'b1; ctrl_nxt.y_in = 1'b1;
                end
            end
            T4: begin
                if (cls.r_alu) begin
                    ctrl_nxt.grc = 1'b1; ctrl_nxt.r_out = 1'b1; ctrl_nxt.z_in = 1'b1;
                    alu_nxt = ALUW'(opcode);
                end
                if (cls.i_alu) begin
                    ctrl_nxt.c_out = 1'b1; ctrl_nxt.z_in = 1'b1;
                    alu_nxt = ALUW'(opcode);
                end
                if (cls.ldi | cls.ld | cls.st) begin
                    ctrl_nxt.c_out = 1'b1; ctrl_nxt.z_in = 1'b1;
                    alu_nxt = OP_ADD;
                end
                if (cls.br) begin
                    ctrl_nxt.pc_out = 1'b1; ctrl_nxt.y_in = 1'b1;
                end
                if (cls.muldiv) begin
                    ctrl_nxt.grb = 1'b1; ctrl_nxt.r_out = 1'b1; ctrl_nxt.z_in = 1'b1;
                    alu_nxt = ALUW'(opcode);
                end
            end
            T5: begin
                if (cls.r_alu | cls.i_alu | cls.ldi) begin
                    ctrl_nxt.zlow_out = 1'b1; ctrl_nxt.gra = 1'b1; ctrl_nxt.r_in = 1'b1;
                end
                if (cls.ld | cls.st) begin
                    ctrl_nxt.zlow_out = 1'b1; ctrl_nxt.mar_in = 1'b1;
                end
                if (cls.br) begin
                    ctrl_nxt.c_out = 1'b1; ctrl_nxt.z_in = 1'b1;
                    alu_nxt = OP_ADD;
                end
                if (cls.muldiv) begin
                    ctrl_nxt.zlow_out = 1'b1; ctrl_nxt.lo_in = 1'b1;
                end
            end
            T6: begin
                if (cls.ld) begin
                    ctrl_nxt.ram_read = 1'b1; ctrl_nxt.md_read = 1'b1;
                    ctrl_nxt.mdr_in   = 1'b1;
                end
                if (cls.st) begin
                    ctrl_nxt.gra = 1'b1; ctrl_nxt.r_out = 1'b1; ctrl_nxt.mdr_in = 1'b1;
                end
                if (cls.br) begin
                    ctrl_nxt.zlow_out = 1'b1;
                    br_t6_nxt = 1'b1;
                end
                if (cls.muldiv) begin
                    ctrl_nxt.zhigh_out = 1'b1; ctrl_nxt.hi_in = 1'b1;
                end
            end
            T7: begin
                if (cls.ld) begin
                    ctrl_nxt.mdr_out = 1'b1; ctrl_nxt.gra = 1'b1; ctrl_nxt.r_in = 1'b1;
                end
                if (cls.st) ctrl_nxt.ram_write = 1'b1;
            end
            default: ;
        endcase
    end

    // State, stop latch and registered control word; clear aborts everything.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state     <= T0;
            primed    <= 1'b0;
            stop_pend <= 1'b0;
            ctrl_q    <= '0;
            alu_q     <= '0;
            run_q     <= 1'b1;
            br_t6_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            primed    <= 1'b1;
            stop_pend <= (state_nxt == HALT) ? 1'b0 : (stop_pend | stop);
            ctrl_q    <= ctrl_nxt;
            alu_q     <= alu_nxt;
            run_q     <= (state_nxt != HALT);
            br_t6_q   <= br_t6_nxt;
        end
    end

    assign run       = run_q;
    assign alu_op    = alu_q;
    assign PCout     = ctrl_q.pc_out;
    assign MARin     = ctrl_q.mar_in;
    assign IncPC     = ctrl_q.inc_pc;
    // Branch target load follows CON live during br T6 only.
    assign PCin      = ctrl_q.pc_in | (br_t6_q & CON);
    assign MDRin     = ctrl_q.mdr_in;
    assign MDRout    = ctrl_q.mdr_out;
    assign IRin      = ctrl_q.ir_in;
    assign Yin       = ctrl_q.y_in;
    assign Zin       = ctrl_q.z_in;
    assign Zlowout   = ctrl_q.zlow_out;
    assign Zhighout  = ctrl_q.zhigh_out;
    assign Gra       = ctrl_q.gra;
    assign Grb       = ctrl_q.grb;
    assign Grc       = ctrl_q.grc;
    assign Rin       = ctrl_q.r_in;
    assign Rout      = ctrl_q.r_out;
    assign BAout     = ctrl_q.ba_out;
    assign Cout      = ctrl_q.c_out;
    assign HIin      = ctrl_q.hi_in;
    assign HIout     = ctrl_q.hi_out;
    assign LOin      = ctrl_q.lo_in;
    assign LOout     = ctrl_q.lo_out;
    assign CONin     = ctrl_q.con_in;
    assign MD_read   = ctrl_q.md_read;
    assign ram_read  = ctrl_q.ram_read;
    assign ram_write = ctrl_q.ram_write;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] instruction = '0;
  logic        CON = 1'b0;
  logic        stop = 1'b0;
  logic        run, PCout, MARin, IncPC, PCin, MDRin, MDRout, IRin, Yin, Zin;
  logic        Zlowout, Zhighout, Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic        HIin, HIout, LOin, LOout, CONin, MD_read, ram_read, ram_write;
  logic [4:0]  alu_op;

  always #5 clock = ~clock;

  control_unit dut (
    .clock(clock), .clear(clear), .instruction(instruction), .CON(CON),
    .stop(stop), .run(run), .PCout(PCout), .MARin(MARin), .IncPC(IncPC),
    .PCin(PCin), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout), .Gra(Gra),
    .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Cout(Cout), .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
    .CONin(CONin), .MD_read(MD_read), .ram_read(ram_read),
    .ram_write(ram_write), .alu_op(alu_op)
  );

  localparam logic [25:0] M_PCOUT  = 26'b1 << 0;
  localparam logic [25:0] M_MARIN  = 26'b1 << 1;
  localparam logic [25:0] M_INCPC  = 26'b1 << 2;
  localparam logic [25:0] M_PCIN   = 26'b1 << 3;
  localparam logic [25:0] M_MDRIN  = 26'b1 << 4;
  localparam logic [25:0] M_MDROUT = 26'b1 << 5;
  localparam logic [25:0] M_IRIN   = 26'b1 << 6;
  localparam logic [25:0] M_YIN    = 26'b1 << 7;
  localparam logic [25:0] M_ZIN    = 26'b1 << 8;
  localparam logic [25:0] M_ZLO    = 26'b1 << 9;
  localparam logic [25:0] M_ZHI    = 26'b1 << 10;
  localparam logic [25:0] M_GRA    = 26'b1 << 11;
  localparam logic [25:0] M_GRB    = 26'b1 << 12;
  localparam logic [25:0] M_GRC    = 26'b1 << 13;
  localparam logic [25:0] M_RIN    = 26'b1 << 14;
  localparam logic [25:0] M_ROUT   = 26'b1 << 15;
  localparam logic [25:0] M_BAOUT  = 26'b1 << 16;
  localparam logic [25:0] M_COUT   = 26'b1 << 17;
  localparam logic [25:0] M_HIIN   = 26'b1 << 18;
  localparam logic [25:0] M_HIOUT  = 26'b1 << 19;
  localparam logic [25:0] M_LOIN   = 26'b1 << 20;
  localparam logic [25:0] M_LOOUT  = 26'b1 << 21;
  localparam logic [25:0] M_CONIN  = 26'b1 << 22;
  localparam logic [25:0] M_MDRD   = 26'b1 << 23;
  localparam logic [25:0] M_RAMRD  = 26'b1 << 24;
  localparam logic [25:0] M_RAMWR  = 26'b1 << 25;

  localparam logic [4:0] A_ADD = 5'b00011;

  logic [31:0] obs;
  assign obs = {run, alu_op, ram_write, ram_read, MD_read, CONin, LOout, LOin,
                HIout, HIin, Cout, BAout, Rout, Rin, Grc, Grb, Gra, Zhighout,
                Zlowout, Zin, Yin, IRin, MDRout, MDRin, PCin, IncPC, MARin, PCout};

  typedef struct {
    string       tag;
    logic        clr;
    logic        stp;
    logic        con;
    logic [31:0] ir;
    logic [31:0] word;
  } step_t;

  step_t sb[$];

  logic        d_clear = 1'b0;
  logic        d_stop  = 1'b0;
  logic        d_con   = 1'b0;
  logic [31:0] d_ir    = '0;
  int          total = 0;
  int          bad   = 0;

  function automatic logic [31:0] w(input logic [4:0] alu, input logic [25:0] m);
    return {1'b1, alu, m};
  endfunction

  localparam logic [31:0] W_HALT = 32'h0;
  localparam logic [31:0] W_IDLE = 32'h8000_0000;
  localparam logic [31:0] W_T0   = {1'b1, A_ADD, M_PCOUT | M_MARIN | M_INCPC | M_ZIN};

  task automatic push(input string tag, input logic [31:0] word);
    step_t e;
    e.tag = tag; e.clr = d_clear; e.stp = d_stop; e.con = d_con;
    e.ir = d_ir; e.word = word;
    sb.push_back(e);
  endtask

  task automatic fetch(input string name, input logic [31:0] ir);
    push({name, "_T0"}, w(A_ADD, M_PCOUT | M_MARIN | M_INCPC | M_ZIN));
    d_ir = ir;
    push({name, "_T1"}, w(5'd0, M_ZLO | M_PCIN | M_RAMRD | M_MDRD | M_MDRIN));
    push({name, "_T2"}, w(5'd0, M_MDROUT | M_IRIN));
  endtask

  task automatic alu_tail(input string name, input logic [4:0] op, input logic imm);
    push({name, "_T3"}, w(5'd0, M_GRB | M_ROUT | M_YIN));
    push({name, "_T4"}, w(op, (imm ? M_COUT : (M_GRC | M_ROUT)) | M_ZIN));
    push({name, "_T5"}, w(5'd0, M_ZLO | M_GRA | M_RIN));
  endtask

  task automatic addr_calc(input string name);
    push({name, "_T3"}, w(5'd0, M_GRB | M_BAOUT | M_YIN));
    push({name, "_T4"}, w(A_ADD, M_COUT | M_ZIN));
  endtask

  initial begin
    step_t e;
    logic  seen;

    d_clear = 1'b0;
    push("rst0", W_IDLE);
    push("rst1", W_IDLE);
    d_clear = 1'b1;
    fetch("addi", 32'h5108_0005);
    alu_tail("addi", 5'b01010, 1'b1);

    fetch("brT", 32'h2098_001B);
    push("brT_T3", w(5'd0, M_GRA | M_ROUT | M_CONIN));
    push("brT_T4", w(5'd0, M_PCOUT | M_YIN));
    push("brT_T5", w(A_ADD, M_COUT | M_ZIN));
    d_con = 1'b1;
    push("brT_T6", w(5'd0, M_ZLO | M_PCIN));
    d_con = 1'b0;

    fetch("brF", 32'h2098_001B);
    d_con = 1'b1;
    push("brF_T3", w(5'd0, M_GRA | M_ROUT | M_CONIN));
    push("brF_T4", w(5'd0, M_PCOUT | M_YIN));
    push("brF_T5", w(A_ADD, M_COUT | M_ZIN));
    d_con = 1'b0;
    push("brF_T6", w(5'd0, M_ZLO));
    d_con = 1'b1;

    fetch("st", 32'h1080_0010);
    d_con = 1'b0;
    addr_calc("st");
    push("st_T5", w(5'd0, M_ZLO | M_MARIN));
    push("st_T6", w(5'd0, M_GRA | M_ROUT | M_MDRIN));
    push("st_T7", w(5'd0, M_RAMWR));

    fetch("ld", 32'h0088_0000);
    addr_calc("ld");
    push("ld_T5", w(5'd0, M_ZLO | M_MARIN));
    push("ld_T6", w(5'd0, M_RAMRD | M_MDRD | M_MDRIN));
    push("ld_T7", w(5'd0, M_MDROUT | M_GRA | M_RIN));

    fetch("ldr", 32'h0088_0000);
    addr_calc("ldr");
    push("ldr_T5", w(5'd0, M_ZLO | M_MARIN));
    d_clear = 1'b0;
    push("ldr_rst", W_IDLE);
    d_clear = 1'b1;

    fetch("jr", 32'h7800_0000);
    push("jr_T3", w(5'd0, M_GRA | M_ROUT | M_PCIN));
    fetch("mfhi", 32'h8000_0000);
    push("mfhi_T3", w(5'd0, M_HIOUT | M_GRA | M_RIN));
    fetch("mflo", 32'h8800_0000);
    push("mflo_T3", w(5'd0, M_LOOUT | M_GRA | M_RIN));
    fetch("ldi", 32'h0800_0000);
    addr_calc("ldi");
    push("ldi_T5", w(5'd0, M_ZLO | M_GRA | M_RIN));
    fetch("add", 32'h1800_0000);
    alu_tail("add", 5'b00011, 1'b0);

    fetch("nop", 32'hC000_0000);
    fetch("undef", 32'hA000_0000);

    fetch("mul", 32'h6888_0000);
`ifdef CONTROL_UNIT_MULDIV_EN
    push("mul_T3", w(5'd0, M_GRA | M_ROUT | M_YIN));
    push("mul_T4", w(5'b01101, M_GRB | M_ROUT | M_ZIN));
    push("mul_T5", w(5'd0, M_ZLO | M_LOIN));
    push("mul_T6", w(5'd0, M_ZHI | M_HIIN));
`endif

    fetch("sub", 32'h2800_0000);
    push("sub_T3", w(5'd0, M_GRB | M_ROUT | M_YIN));
    push("sub_T4", w(5'b00101, M_GRC | M_ROUT | M_ZIN));
    d_stop = 1'b1;
    push("sub_T5", w(5'd0, M_ZLO | M_GRA | M_RIN));
    d_stop = 1'b0;
    for (int unsigned i = 0; i < 4; i++) push("stop_halt", W_HALT);
    d_clear = 1'b0;
    push("stop_rst", W_IDLE);
    d_clear = 1'b1;

    fetch("halt", 32'hC800_0000);
    for (int unsigned i = 0; i < 20; i++) begin
      d_stop = i[0];
      d_con  = i[1];
      push("halt_hold", W_HALT);
    end
    d_stop = 1'b0;
    d_con  = 1'b0;
    d_clear = 1'b0;
    push("halt_rst", W_IDLE);
    d_clear = 1'b1;
    fetch("post", 32'hC000_0000);
    push("post_T0", w(A_ADD, M_PCOUT | M_MARIN | M_INCPC | M_ZIN));

    while (sb.size() > 0) begin
      e = sb.pop_front();
      clear       = e.clr;
      stop        = e.stp;
      CON         = e.con;
      instruction = e.ir;
      @(posedge clock);
      #1;
      total++;
      assert (obs === e.word) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.word);
      end
    end

    stop  = 1'b0;
    CON   = 1'b0;
    clear = 1'b0;
    @(posedge clock);
    #1;
    total++;
    if (obs !== W_IDLE) begin
      bad++;
      $error("FAIL reset_state observed=%h expected=%h", obs, W_IDLE);
    end

    clear = 1'b1;
    seen  = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      @(posedge clock);
      #1;
      if (obs === W_T0) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $error("FAIL fetch_wait expired: no T0 strobes within 8 cycles of reset release");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
